// File: rtl/dallanma_ongorucu_pkg.sv
// Shared definitions for the branch predictor: 2-bit counter encodings and the instruction step.
package dallanma_ongorucu_pkg;

  typedef enum logic [1:0] {
    GUCLU_ATLAMAZ = 2'b00,
    ZAYIF_ATLAMAZ = 2'b01,
    ZAYIF_ATLAR   = 2'b10,
    GUCLU_ATLAR   = 2'b11
  } sayac_e;

  localparam int unsigned KOMUT_ADIM = 4;

  function automatic logic atla_mi(input sayac_e s);
    return s[1];
  endfunction

endpackage

// File: rtl/dallanma_ongorucu_doyumlu_sayac_2b.sv
// Next-state function of a 2-bit saturating taken/not-taken counter.
module doyumlu_sayac_2b
  import dallanma_ongorucu_pkg::*;
(
  input  sayac_e mevcut,
  input  logic   atladi,
  output sayac_e sonraki
);

  always_comb begin
    // NOTE: the output gets a default before the case so no path leaves it unassigned (no latch).
    sonraki = mevcut;
    unique case (mevcut)
      GUCLU_ATLAMAZ: sonraki = atladi ? ZAYIF_ATLAMAZ : GUCLU_ATLAMAZ;
      ZAYIF_ATLAMAZ: sonraki = atladi ? ZAYIF_ATLAR   : GUCLU_ATLAMAZ;
      ZAYIF_ATLAR:   sonraki = atladi ? GUCLU_ATLAR   : ZAYIF_ATLAMAZ;
      GUCLU_ATLAR:   sonraki = atladi ? GUCLU_ATLAR   : ZAYIF_ATLAR;
      default:       sonraki = mevcut;
    endcase
  end

endmodule

// File: rtl/dallanma_ongorucu.sv
// Fetch-side branch predictor: bimodal 2-bit BHT plus direct-mapped BTB.
// Define DALLANMA_ONGORUCU_GSHARE_EN to XOR a global history into the BHT index.
module dallanma_ongorucu
  import dallanma_ongorucu_pkg::*;
#(
  parameter int PS_W        = 32,
  parameter int TABLO_BOYUT = 64,
  parameter int GECMIS_W    = 6,
  parameter int SAYAC_W     = 16
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [PS_W-1:0]    ps_i,
  input  logic               ps_gecerli_i,
  output logic               ongoru_atla_o,
  output logic [PS_W-1:0]    ongoru_ps_o,
  input  logic               guncelle_gecerli_i,
  input  logic               guncelle_atladi_i,
  input  logic               dallanma_hata_i,
  input  logic [PS_W-1:0]    guncelle_ps_i,
  input  logic [PS_W-1:0]    guncelle_hedef_ps_i,
  output logic [SAYAC_W-1:0] hata_sayisi_o
);

  localparam int IDX_W = $clog2(TABLO_BOYUT);
  localparam int TAG_W = PS_W - IDX_W - 2;

  sayac_e                  sayac       [TABLO_BOYUT];
  logic [TABLO_BOYUT-1:0]  btb_gecerli;
  logic [TAG_W-1:0]        btb_tag     [TABLO_BOYUT];
  logic [PS_W-1:0]         btb_hedef   [TABLO_BOYUT];
  logic [SAYAC_W-1:0]      hata_sayisi;

  logic [IDX_W-1:0] o_idx;
  logic [IDX_W-1:0] o_bht_idx;
  logic [TAG_W-1:0] o_tag;
  logic [IDX_W-1:0] g_idx;
  logic [IDX_W-1:0] g_bht_idx;
  logic [TAG_W-1:0] g_tag;
  logic             o_hit;
  sayac_e           sayac_sonraki;

  assign o_idx = ps_i[IDX_W+1:2];
  assign o_tag = ps_i[PS_W-1:IDX_W+2];
  assign g_idx = guncelle_ps_i[IDX_W+1:2];
  assign g_tag = guncelle_ps_i[PS_W-1:IDX_W+2];

  // Byte-offset bits never take part in prediction.
  logic unused_ps_bits;
  assign unused_ps_bits = ^{ps_i[1:0], guncelle_ps_i[1:0]};

`ifdef DALLANMA_ONGORUCU_GSHARE_EN
  logic [GECMIS_W-1:0] ghr;

  // History advances only on resolved branches, so it never needs repair.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ghr <= '0;
    end else if (guncelle_gecerli_i) begin
      ghr <= {ghr[GECMIS_W-2:0], guncelle_atladi_i};
    end
  end

  assign o_bht_idx = o_idx ^ IDX_W'(ghr);
  assign g_bht_idx = g_idx ^ IDX_W'(ghr);
`else
  localparam int unused_gecmis_w = GECMIS_W;

  assign o_bht_idx = o_idx;
  assign g_bht_idx = g_idx;
`endif

  // Prediction reads the registered tables only, so an update in the same cycle is not bypassed.
  assign o_hit         = btb_gecerli[o_idx] && (btb_tag[o_idx] == o_tag);
  assign ongoru_atla_o = rst_ni && ps_gecerli_i && o_hit && atla_mi(sayac[o_bht_idx]);
  assign ongoru_ps_o   = ongoru_atla_o ? btb_hedef[o_idx] : ps_i + PS_W'(KOMUT_ADIM);

  doyumlu_sayac_2b u_sayac (
    .mevcut  (sayac[g_bht_idx]),
    .atladi  (guncelle_atladi_i),
    .sonraki (sayac_sonraki)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_ni) begin
      for (int i = 0; i < TABLO_BOYUT; i++) begin
        sayac[i] <= ZAYIF_ATLAMAZ;
      end
      btb_gecerli <= '0;
    end else if (guncelle_gecerli_i) begin
      sayac[g_bht_idx] <= sayac_sonraki;
      if (guncelle_atladi_i) begin
        btb_gecerli[g_idx] <= 1'b1;
      end
    end
  end

  // NOTE: tag and target arrays are deliberately not reset; the valid bits gate every use of them.
  always_ff @(posedge clk_i) begin
    if (guncelle_gecerli_i && guncelle_atladi_i) begin
      btb_tag[g_idx]   <= g_tag;
      btb_hedef[g_idx] <= guncelle_hedef_ps_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hata_sayisi <= '0;
    end else if (guncelle_gecerli_i && dallanma_hata_i && !(&hata_sayisi)) begin
      hata_sayisi <= hata_sayisi + 1'b1;
    end
  end

  assign hata_sayisi_o = hata_sayisi;

endmodule

// File: tb/tb_dallanma_ongorucu.sv
// Self-checking bench for dallanma_ongorucu: vector table, directed corner cases,
// and random traffic compared with a table-level reference model.
module tb_dallanma_ongorucu;

  localparam int PS_W = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [PS_W-1:0] ps;
  logic            ps_v;
  logic            gv, gt, gh;
  logic [PS_W-1:0] gps, ghed;
  logic            atla, atla2;
  logic [PS_W-1:0] nps, nps2;
  logic [15:0]     hata;
  logic [1:0]      hata2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dallanma_ongorucu dut (
    .clk_i(clk), .rst_ni(rst_n), .ps_i(ps), .ps_gecerli_i(ps_v),
    .ongoru_atla_o(atla), .ongoru_ps_o(nps),
    .guncelle_gecerli_i(gv), .guncelle_atladi_i(gt), .dallanma_hata_i(gh),
    .guncelle_ps_i(gps), .guncelle_hedef_ps_i(ghed), .hata_sayisi_o(hata)
  );

  dallanma_ongorucu #(.SAYAC_W(2)) dut2 (
    .clk_i(clk), .rst_ni(rst_n), .ps_i(ps), .ps_gecerli_i(ps_v),
    .ongoru_atla_o(atla2), .ongoru_ps_o(nps2),
    .guncelle_gecerli_i(gv), .guncelle_atladi_i(gt), .dallanma_hata_i(gh),
    .guncelle_ps_i(gps), .guncelle_hedef_ps_i(ghed), .hata_sayisi_o(hata2)
  );

  // Reference model: plain arrays indexed by the PC fields.
  int          m_cnt [64];
  bit          m_val [64];
  logic [23:0] m_tag [64];
  logic [31:0] m_hed [64];
  logic [5:0]  m_ghr;
  int          m_hata, m_hata2;

  function automatic void m_reset();
    for (int i = 0; i < 64; i++) begin
      m_cnt[i] = 1;
      m_val[i] = 0;
    end
    m_ghr   = '0;
    m_hata  = 0;
    m_hata2 = 0;
  endfunction

  function automatic void m_pred(input logic [31:0] p, input logic v,
                                 output logic a, output logic [31:0] n);
    int idx, bidx;
    idx  = int'(p[7:2]);
    bidx = idx ^ int'(m_ghr);
    a = v && m_val[idx] && (m_tag[idx] == p[31:8]) && (m_cnt[bidx] >= 2);
    n = a ? m_hed[idx] : p + 32'd4;
  endfunction

  function automatic void m_update();
    int idx, bidx;
    if (!gv) return;
    idx  = int'(gps[7:2]);
    bidx = idx ^ int'(m_ghr);
    if (gt) begin
      m_cnt[bidx] = (m_cnt[bidx] == 3) ? 3 : m_cnt[bidx] + 1;
      m_val[idx]  = 1;
      m_tag[idx]  = gps[31:8];
      m_hed[idx]  = ghed;
    end else begin
      m_cnt[bidx] = (m_cnt[bidx] == 0) ? 0 : m_cnt[bidx] - 1;
    end
    if (gh) begin
      if (m_hata < 65535) m_hata++;
      if (m_hata2 < 3) m_hata2++;
    end
`ifdef DALLANMA_ONGORUCU_GSHARE_EN
    m_ghr = {m_ghr[4:0], gt};
`endif
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_n) m_update();
    #1;
  endtask

  task automatic upd(input logic t, input logic h, input logic [31:0] pc, input logic [31:0] tgt);
    gv = 1'b1; gt = t; gh = h; gps = pc; ghed = tgt;
    step();
    gv = 1'b0; gh = 1'b0;
  endtask

  task automatic pred_chk(input string name, input logic [31:0] p, input logic ea, input logic [31:0] en);
    ps = p; ps_v = 1'b1;
    #1;
    check({name, "_atla"}, 64'(atla), 64'(ea));
    check({name, "_ps"}, 64'(nps), 64'(en));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    m_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [31:0] ps;
    logic        v;
    logic        exp_atla;
    logic [31:0] exp_ps;
  } vektor_t;

  vektor_t vt [4];

  initial begin
    logic        ea;
    logic [31:0] en;
    logic [31:0] pcs [8];

    vt[0] = '{ps: 32'h0000_0100, v: 1'b1, exp_atla: 1'b0, exp_ps: 32'h0000_0104};
    vt[1] = '{ps: 32'hFFFF_FFFC, v: 1'b1, exp_atla: 1'b0, exp_ps: 32'h0000_0000};
    vt[2] = '{ps: 32'h0000_0100, v: 1'b0, exp_atla: 1'b0, exp_ps: 32'h0000_0104};
    vt[3] = '{ps: 32'h7FFF_FFFE, v: 1'b1, exp_atla: 1'b0, exp_ps: 32'h8000_0002};

    gv = 0; gt = 0; gh = 0; gps = '0; ghed = '0; ps = '0; ps_v = 0;
    rst_n = 1'b0;
    m_reset();
    ps = 32'h100; ps_v = 1'b1;
    #3;
    check("in_reset_atla", 64'(atla), 64'd0);
    check("in_reset_ps", 64'(nps), 64'h104);
    do_reset();

    for (int i = 0; i < 4; i++) begin
      ps = vt[i].ps; ps_v = vt[i].v;
      #1;
      check($sformatf("vec%0d_atla", i), 64'(atla), 64'(vt[i].exp_atla));
      check($sformatf("vec%0d_ps", i), 64'(nps), 64'(vt[i].exp_ps));
    end
    check("reset_hata", 64'(hata), 64'd0);

`ifndef DALLANMA_ONGORUCU_GSHARE_EN
    // Training and hysteresis on one PC.
    upd(1, 0, 32'h100, 32'h200);
    upd(1, 0, 32'h100, 32'h200);
    pred_chk("train2", 32'h100, 1'b1, 32'h200);
    upd(0, 0, 32'h100, 32'h0);
    pred_chk("nt1_still_taken", 32'h100, 1'b1, 32'h200);
    upd(0, 0, 32'h100, 32'h0);
    pred_chk("nt2_not_taken", 32'h100, 1'b0, 32'h104);

    // Alias: 0x200 shares index 0 with 0x100 and evicts its BTB entry.
    upd(1, 0, 32'h100, 32'h200);
    pred_chk("alias_pre", 32'h100, 1'b1, 32'h200);
    upd(1, 0, 32'h200, 32'h300);
    pred_chk("alias_miss", 32'h100, 1'b0, 32'h104);
    pred_chk("alias_new", 32'h200, 1'b1, 32'h300);

    // Same-cycle predict and update: prediction sees the pre-update tables.
    do_reset();
    @(posedge clk); #1;
    ps = 32'h100; ps_v = 1'b1;
    gv = 1; gt = 1; gh = 0; gps = 32'h100; ghed = 32'h200;
    #1;
    check("same_cycle_atla", 64'(atla), 64'd0);
    check("same_cycle_ps", 64'(nps), 64'h104);
    step();
    gv = 0;
    pred_chk("after_same_cycle", 32'h100, 1'b1, 32'h200);
    upd(1, 0, 32'h100, 32'h200);
    pred_chk("after_second", 32'h100, 1'b1, 32'h200);
    pred_chk("wrap_untrained", 32'hFFFF_FFFC, 1'b0, 32'h0);

    // Mispredict counter, incl. saturation of a 2-bit instance and gating by valid.
    do_reset();
    for (int i = 0; i < 10; i++) upd(0, 1, 32'h400 + 32'(i * 4), 32'h0);
    check("hata_ten", 64'(hata), 64'd10);
    check("hata_sat2", 64'(hata2), 64'd3);
    gv = 0; gh = 1;
    step(); step(); step();
    gh = 0;
    check("hata_ignored", 64'(hata), 64'd10);

    // Asynchronous reset in the middle of an update cycle.
    upd(1, 0, 32'h100, 32'h200);
    upd(1, 0, 32'h100, 32'h200);
    pred_chk("pre_reset", 32'h100, 1'b1, 32'h200);
    gv = 1; gt = 1; gh = 1; gps = 32'h100; ghed = 32'h200;
    #2;
    rst_n = 1'b0;
    m_reset();
    #1;
    check("mid_reset_atla", 64'(atla), 64'd0);
    check("mid_reset_ps", 64'(nps), 64'h104);
    check("mid_reset_hata", 64'(hata), 64'd0);
    gv = 0; gh = 0;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    pred_chk("post_reset", 32'h100, 1'b0, 32'h104);
`endif

    // Random traffic over a small PC set with aliasing and junk low bits.
    do_reset();
    pcs[0] = 32'h100; pcs[1] = 32'h200; pcs[2] = 32'h104; pcs[3] = 32'h1000;
    pcs[4] = 32'h3FC; pcs[5] = 32'h500; pcs[6] = 32'hFFFF_FFFC; pcs[7] = 32'h108;
    for (int c = 0; c < 600; c++) begin
      ps   = pcs[$urandom_range(0, 7)] | 32'($urandom_range(0, 3));
      ps_v = 1'($urandom_range(0, 3) != 0);
      gv   = 1'($urandom_range(0, 2) != 0);
      gt   = 1'($urandom);
      gh   = 1'($urandom);
      gps  = pcs[$urandom_range(0, 7)];
      ghed = $urandom & 32'hFFFF_FFFC;
      #1;
      m_pred(ps, ps_v, ea, en);
      check("rnd_atla", 64'(atla), 64'(ea));
      check("rnd_ps", 64'(nps), 64'(en));
      check("rnd_hata", 64'(hata), 64'(m_hata));
      check("rnd_hata2", 64'(hata2), 64'(m_hata2));
      step();
    end
    gv = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
